// File: rtl/gc_trap_sequencer.sv
// Global-control sequencer: arbitrates ID-matched exceptions, sequences ifence/mret/sret
// drains, interrupts and the reset-time clear, and drives holds, PC override and trap record.

module gc_src_match #(
    parameter int ID_W = 3
) (
    input  logic            valid,
    input  logic [ID_W-1:0] id,
    input  logic [ID_W-1:0] oldest_id,
    output logic            hit
);
    assign hit = valid && (id == oldest_id);
endmodule

module gc_trap_sequencer #(
    parameter int          NUM_SRC       = 4,
    parameter int          ID_W          = 3,
    parameter int          CLEAR_DEPTH   = 64,
    parameter int          DRAIN_TIMEOUT = 0,
    parameter logic [31:0] RESET_VEC     = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_new,
    input  logic [1:0]              issue_op,
    input  logic [31:0]             issue_pc_p4,
    input  logic [NUM_SRC-1:0]      exc_valid,
    input  logic [NUM_SRC*ID_W-1:0] exc_id,
    input  logic [NUM_SRC*5-1:0]    exc_code,
    input  logic [NUM_SRC*32-1:0]   exc_tval,
    output logic [NUM_SRC-1:0]      exc_ack,
    input  logic [ID_W-1:0]         oldest_id,
    input  logic [31:0]             oldest_pc,
    input  logic                    oldest_pc_invalid,
    input  logic [ID_W:0]           inflight_count,
    input  logic                    sq_empty,
    input  logic                    stores_pending,
    input  logic                    interrupt_pending,
    input  logic                    csr_busy,
    input  logic [31:0]             trap_vector,
    input  logic [31:0]             epc,
    output logic                    fetch_hold,
    output logic                    issue_hold,
    output logic                    retire_hold,
    output logic                    writeback_suppress,
    output logic                    init_clear,
    output logic                    sq_flush,
    output logic                    pc_override,
    output logic [31:0]             pc_out,
    output logic                    trap_valid,
    output logic [4:0]              trap_code,
    output logic [31:0]             trap_tval,
    output logic [31:0]             trap_pc,
    output logic                    interrupt_taken,
    output logic                    interrupt_pc_capture,
    output logic                    mret,
    output logic                    sret,
    output logic                    drain_timeout
);
    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_DRAIN, S_FLUSH, S_DISCARD} state_t;
    localparam int CW = $clog2(CLEAR_DEPTH);

    state_t             state, next_state;
    logic [CW-1:0]      clr_cnt;
    logic [1:0]         op_q;
    logic [31:0]        pc_p4_q, wd_cnt, flush_pc;
    logic               interrupt_req, cap_pend;
    logic [NUM_SRC-1:0] hit, win;
    logic               int_elig, op_done;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        gc_src_match #(.ID_W(ID_W)) u_match (
            .valid     (exc_valid[i]),
            .id        (exc_id[i*ID_W +: ID_W]),
            .oldest_id (oldest_id),
            .hit       (hit[i])
        );
    end

    // isolate lowest set bit: lowest-index source wins
    assign win      = hit & (~hit + NUM_SRC'(1));
    assign int_elig = interrupt_req && !csr_busy;
    assign op_done  = (state == S_DRAIN) && (op_q != 2'd0) && (inflight_count == '0) && sq_empty;
    assign interrupt_pc_capture = cap_pend && !oldest_pc_invalid;

    always_comb begin
        next_state      = state;
        exc_ack         = '0;
        trap_valid      = 1'b0;
        interrupt_taken = 1'b0;
        mret            = 1'b0;
        sret            = 1'b0;
        trap_code       = '0;
        trap_tval       = '0;
        trap_pc         = '0;
        case (state)
            S_CLEAR: if (clr_cnt == CW'(CLEAR_DEPTH-1)) next_state = S_IDLE;
            S_IDLE, S_DRAIN: begin
                if (|hit) begin
                    next_state = S_FLUSH;
                    trap_valid = 1'b1;
                    exc_ack    = win;
                    trap_pc    = oldest_pc;
                end else if (int_elig) begin
                    next_state      = S_FLUSH;
                    interrupt_taken = 1'b1;
                end else if (state == S_IDLE) begin
                    if (issue_new || (|exc_valid)) next_state = S_DRAIN;
                end else if (op_done) begin
                    next_state = S_FLUSH;
                    mret       = (op_q == 2'd2);
                    sret       = (op_q == 2'd3);
                end else if (op_q == 2'd0 && exc_valid == '0) begin
                    next_state = S_IDLE;
                end
            end
            S_FLUSH:   next_state = S_DISCARD;
            S_DISCARD: if (inflight_count == '0 && !stores_pending) next_state = S_IDLE;
            default:   next_state = S_CLEAR;
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
            if (exc_ack[i]) begin
                trap_code = exc_code[i*5 +: 5];
                trap_tval = exc_tval[i*32 +: 32];
            end
        end
    end

    assign flush_pc = (trap_valid || interrupt_taken) ? trap_vector :
                      (op_q == 2'd1) ? pc_p4_q : epc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_CLEAR;
            clr_cnt            <= '0;
            op_q               <= '0;
            pc_p4_q            <= '0;
            wd_cnt             <= '0;
            interrupt_req      <= 1'b0;
            cap_pend           <= 1'b0;
            init_clear         <= 1'b1;
            fetch_hold         <= 1'b1;
            issue_hold         <= 1'b1;
            writeback_suppress <= 1'b1;
            retire_hold        <= 1'b0;
            sq_flush           <= 1'b0;
            pc_override        <= 1'b0;
            pc_out             <= '0;
            drain_timeout      <= 1'b0;
        end else begin
            state              <= next_state;
            clr_cnt            <= (state == S_CLEAR) ? clr_cnt + CW'(1) : '0;
            init_clear         <= (next_state == S_CLEAR);
            fetch_hold         <= next_state inside {S_CLEAR, S_DRAIN, S_FLUSH};
            issue_hold         <= csr_busy || (next_state != S_IDLE);
            writeback_suppress <= next_state inside {S_CLEAR, S_DISCARD};
            retire_hold        <= (next_state == S_FLUSH) && !csr_busy;
            sq_flush           <= (state == S_DISCARD) && (next_state == S_IDLE);
            pc_override        <= ((state == S_CLEAR) && (next_state == S_IDLE)) || (state == S_FLUSH);
            // the target is frozen on FLUSH entry; the override itself goes out a cycle later
            if (state == S_CLEAR && next_state == S_IDLE) pc_out <= RESET_VEC;
            else if (next_state == S_FLUSH)               pc_out <= flush_pc;
            if (state == S_IDLE && next_state == S_DRAIN) begin
                op_q    <= issue_new ? issue_op : 2'd0;
                if (issue_new) pc_p4_q <= issue_pc_p4;
            end
            if (interrupt_taken)        interrupt_req <= 1'b0;
            else if (interrupt_pending) interrupt_req <= 1'b1;
            if (interrupt_taken)           cap_pend <= 1'b1;
            else if (interrupt_pc_capture) cap_pend <= 1'b0;
            if (state == S_DRAIN) begin
                if (wd_cnt != '1) wd_cnt <= wd_cnt + 32'd1;
                if (DRAIN_TIMEOUT != 0 && wd_cnt == 32'(DRAIN_TIMEOUT-1)) drain_timeout <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    a_issue_idle: assert property (@(posedge clk) disable iff (rst) issue_new |-> state == S_IDLE);
endmodule
